// File: rtl/cruise_pkg.sv
// Shared definitions for the cruise-control regulator: state encodings, speed width, default limits.
package cruise_pkg;

    localparam int SPEED_W = 8;

    localparam logic [SPEED_W-1:0] DEF_MIN_SPEED   = 8'd30;
    localparam logic [SPEED_W-1:0] DEF_MAX_SPEED   = 8'd200;
    localparam int                 DEF_STEP_CYCLES = 16;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        STANDBY = 2'd1,
        HOLD    = 2'd2,
        ADJUST  = 2'd3
    } cruise_state_t;

endpackage

// File: rtl/btn_edge.sv
// One-flop rising-edge detector for a driver button; a held button produces a single pulse.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= btn;
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/cruise_speed_regulator.sv
// Cruise target owner and throttle command generator driven by the external speed comparator.
// Optional feature: define CRUISE_RESUME_EN to enable resume of a stored target after braking.
module cruise_speed_regulator
    import cruise_pkg::*;
#(
    parameter int MIN_SPEED   = DEF_MIN_SPEED,
    parameter int MAX_SPEED   = DEF_MAX_SPEED,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cruise_on,
    input  logic                set_btn,
    input  logic                resume_btn,
    input  logic                accel_btn,
    input  logic                decel_btn,
    input  logic                brake,
    input  logic [SPEED_W-1:0]  speed,
    input  logic                G,
    input  logic                Eq,
    input  logic                L,
    output logic [SPEED_W-1:0]  target,
    output logic                throttle_up,
    output logic                throttle_down,
    output logic                engaged,
    output logic [1:0]          state
);

    localparam logic [SPEED_W-1:0] MIN_S    = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] MAX_S    = SPEED_W'(MAX_SPEED);
    localparam int                 CNT_W    = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    cruise_state_t      cur_state, next_state;
    logic [SPEED_W-1:0] next_target, step_up_val, step_dn_val;
    logic               target_valid, next_valid;
    logic [CNT_W-1:0]   step_cnt, next_cnt;
    logic               step_up, next_dir;
    logic               set_rise, resume_rise, in_range, one_btn, next_eng;

    btn_edge u_set_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (set_btn),
        .rise  (set_rise)
    );

`ifdef CRUISE_RESUME_EN
    btn_edge u_resume_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (resume_btn),
        .rise  (resume_rise)
    );
`else
    logic unused_cfg;
    assign resume_rise = 1'b0;
    assign unused_cfg  = resume_btn ^ resume_rise;
`endif

    assign in_range    = (speed >= MIN_S) && (speed <= MAX_S);
    assign one_btn     = accel_btn ^ decel_btn;
    assign step_up_val = (target < MAX_S) ? target + 1'b1 : MAX_S;
    assign step_dn_val = (target > MIN_S) ? target - 1'b1 : MIN_S;

    always_comb begin
        next_state  = cur_state;
        next_target = target;
        next_valid  = target_valid;
        next_cnt    = step_cnt;
        next_dir    = step_up;
        if (!cruise_on) begin
            next_state  = OFF;
            next_target = '0;
            next_valid  = 1'b0;
            next_cnt    = '0;
        end else begin
            case (cur_state)
                OFF: next_state = STANDBY;
                STANDBY: begin
                    if (brake) begin
                        next_state = STANDBY;
                    end else if (set_rise && in_range) begin
                        next_state  = HOLD;
                        next_target = speed;
                        next_valid  = 1'b1;
                    end else if (resume_rise && target_valid) begin
                        next_state = HOLD;
                    end
                end
                HOLD, ADJUST: begin
                    if (brake) begin
                        next_state = STANDBY;
                        next_cnt   = '0;
`ifndef CRUISE_RESUME_EN
                        // Without resume there is nothing to return to, so braking forgets the target.
                        next_target = '0;
                        next_valid  = 1'b0;
`endif
                    end else if (cur_state == HOLD) begin
                        if (set_rise && in_range) begin
                            next_target = speed;
                            next_valid  = 1'b1;
                        end else if (one_btn) begin
                            next_state  = ADJUST;
                            next_cnt    = '0;
                            next_dir    = accel_btn;
                            next_target = accel_btn ? step_up_val : step_dn_val;
                        end
                    end else if (!one_btn || (accel_btn != step_up)) begin
                        next_state = HOLD;
                        next_cnt   = '0;
                    end else if (step_cnt == CNT_LAST) begin
                        // Repeat step; the counter keeps cycling even when the target is saturated.
                        next_cnt    = '0;
                        next_target = step_up ? step_up_val : step_dn_val;
                    end else begin
                        next_cnt = step_cnt + 1'b1;
                    end
                end
                default: next_state = OFF;
            endcase
        end
    end

    assign next_eng = (next_state == HOLD) || (next_state == ADJUST);

    // Throttle follows the comparator only while engaged and only for a clean one-hot result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state     <= OFF;
            target        <= '0;
            target_valid  <= 1'b0;
            step_cnt      <= '0;
            step_up       <= 1'b0;
            engaged       <= 1'b0;
            throttle_up   <= 1'b0;
            throttle_down <= 1'b0;
        end else begin
            cur_state     <= next_state;
            target        <= next_target;
            target_valid  <= next_valid;
            step_cnt      <= next_cnt;
            step_up       <= next_dir;
            engaged       <= next_eng;
            throttle_up   <= next_eng & L & ~G & ~Eq;
            throttle_down <= next_eng & G & ~Eq & ~L;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// Directed, table-driven bench for cruise_speed_regulator; honours CRUISE_RESUME_EN for resume expectations.
module tb_cruise_speed_regulator;

    typedef struct {
        logic       co, set_b, res_b, acc, dec, brk;
        logic [7:0] spd;
        logic [2:0] gel;
        logic [1:0] est;
        logic [7:0] etgt;
        logic       eup, edn, eeng;
    } vec_t;

`ifdef CRUISE_RESUME_EN
    localparam int K60 = 60, K80 = 80, RS = 2, RT = 80, RE = 1;
`else
    localparam int K60 = 0, K80 = 0, RS = 1, RT = 0, RE = 0;
`endif

    logic       clk, rst_n;
    logic       cruise_on, set_btn, resume_btn, accel_btn, decel_btn, brake;
    logic [7:0] speed;
    logic       G, Eq, L;
    logic [7:0] target;
    logic       throttle_up, throttle_down, engaged;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[30];

    cruise_speed_regulator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cruise_on     (cruise_on),
        .set_btn       (set_btn),
        .resume_btn    (resume_btn),
        .accel_btn     (accel_btn),
        .decel_btn     (decel_btn),
        .brake         (brake),
        .speed         (speed),
        .G             (G),
        .Eq            (Eq),
        .L             (L),
        .target        (target),
        .throttle_up   (throttle_up),
        .throttle_down (throttle_down),
        .engaged       (engaged),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit co, bit sb, bit rb, bit ac, bit dc, bit bk, int spd,
                                bit [2:0] gel, int est, int etgt, bit up, bit dn, bit eng);
        vec_t v;
        v.co = co; v.set_b = sb; v.res_b = rb; v.acc = ac; v.dec = dc; v.brk = bk;
        v.spd = 8'(spd); v.gel = gel; v.est = 2'(est); v.etgt = 8'(etgt);
        v.eup = up; v.edn = dn; v.eeng = eng;
        return v;
    endfunction

    task automatic check_val(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_output(string name, int est, int etgt, bit up, bit dn, bit eng);
        check_val({name, ".state"}, {6'd0, state}, 8'(est));
        check_val({name, ".target"}, target, 8'(etgt));
        check_val({name, ".up"}, {7'd0, throttle_up}, {7'd0, up});
        check_val({name, ".down"}, {7'd0, throttle_down}, {7'd0, dn});
        check_val({name, ".engaged"}, {7'd0, engaged}, {7'd0, eng});
    endtask

    task automatic drive(bit co, bit sb, bit rb, bit ac, bit dc, bit bk, logic [7:0] spd, bit [2:0] gel);
        cruise_on = co; set_btn = sb; resume_btn = rb;
        accel_btn = ac; decel_btn = dc; brake = bk; speed = spd;
        {G, Eq, L} = gel;
    endtask

    task automatic apply_stimulus(vec_t v);
        @(negedge clk);
        drive(v.co, v.set_b, v.res_b, v.acc, v.dec, v.brk, v.spd, v.gel);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_t;
        vecs[0]  = mk(0,0,0,0,0,0, 60,3'b010, 0,  0,0,0,0);
        vecs[1]  = mk(1,0,0,0,0,0, 60,3'b010, 1,  0,0,0,0);
        vecs[2]  = mk(1,1,0,0,0,0, 60,3'b010, 2, 60,0,0,1);
        vecs[3]  = mk(1,1,0,0,0,0, 70,3'b001, 2, 60,1,0,1);
        vecs[4]  = mk(1,0,0,0,0,0, 70,3'b100, 2, 60,0,1,1);
        vecs[5]  = mk(1,0,0,0,0,0, 70,3'b101, 2, 60,0,0,1);
        vecs[6]  = mk(1,0,0,0,0,0, 70,3'b111, 2, 60,0,0,1);
        vecs[7]  = mk(1,1,0,0,0,0, 20,3'b010, 2, 60,0,0,1);
        vecs[8]  = mk(1,0,0,0,0,0, 20,3'b000, 2, 60,0,0,1);
        vecs[9]  = mk(1,1,0,0,0,0,210,3'b010, 2, 60,0,0,1);
        vecs[10] = mk(1,0,0,0,0,1, 80,3'b001, 1,K60,0,0,0);
        vecs[11] = mk(1,1,0,0,0,0, 20,3'b001, 1,K60,0,0,0);
        vecs[12] = mk(1,0,0,0,0,0, 20,3'b001, 1,K60,0,0,0);
        vecs[13] = mk(1,1,0,0,0,0,210,3'b100, 1,K60,0,0,0);
        vecs[14] = mk(1,0,0,0,0,0, 80,3'b010, 1,K60,0,0,0);
        vecs[15] = mk(1,1,0,0,0,0, 80,3'b010, 2, 80,0,0,1);
        vecs[16] = mk(1,0,0,0,0,1, 80,3'b001, 1,K80,0,0,0);
        vecs[17] = mk(1,0,1,0,0,0, 80,3'b010,RS, RT,0,0,RE);
        vecs[18] = mk(1,0,0,0,0,0, 80,3'b010,RS, RT,0,0,RE);
        vecs[19] = mk(1,1,0,0,0,0, 31,3'b010, 2, 31,0,0,1);
        vecs[20] = mk(1,0,0,0,1,0, 31,3'b001, 3, 30,1,0,1);
        vecs[21] = mk(1,0,0,0,1,0, 31,3'b100, 3, 30,0,1,1);
        vecs[22] = mk(1,0,0,0,0,0, 31,3'b010, 2, 30,0,0,1);
        vecs[23] = mk(1,0,0,1,1,0, 31,3'b010, 2, 30,0,0,1);
        vecs[24] = mk(1,0,0,0,0,0, 31,3'b010, 2, 30,0,0,1);
        vecs[25] = mk(1,0,0,1,0,0, 31,3'b010, 3, 31,0,0,1);
        vecs[26] = mk(0,0,0,1,0,1, 31,3'b001, 0,  0,0,0,0);
        vecs[27] = mk(1,0,0,0,0,0, 31,3'b010, 1,  0,0,0,0);
        vecs[28] = mk(1,0,1,0,0,0, 31,3'b010, 1,  0,0,0,0);
        vecs[29] = mk(1,0,0,0,0,0, 31,3'b010, 1,  0,0,0,0);

        rst_n = 1'b0;
        drive(0,0,0,0,0,0,8'd0,3'b010);
        repeat (2) @(posedge clk);
        #1;
        check_output("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d", i), vecs[i].est, vecs[i].etgt,
                         vecs[i].eup, vecs[i].edn, vecs[i].eeng);
        end

        // Accel held near the top: stepping every 16 cycles, saturating at 200.
        @(negedge clk); drive(1,1,0,0,0,0,8'd198,3'b010);
        @(posedge clk); #1;
        check_output("sat_set", 2, 198, 0, 0, 1);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk); drive(1,0,0,1,0,0,8'd198,3'b010);
            @(posedge clk); #1;
            exp_t = 198 + 1 + (n - 1) / 16;
            if (exp_t > 200) exp_t = 200;
            check_val($sformatf("accel_n%0d.target", n), target, 8'(exp_t));
            check_val($sformatf("accel_n%0d.state", n), {6'd0, state}, 8'd3);
        end
        @(negedge clk); drive(1,0,0,0,0,0,8'd198,3'b010);
        @(posedge clk); #1;
        check_output("accel_release", 2, 200, 0, 0, 1);

        // Decel held from 100 for 33 cycles lands at 97.
        @(negedge clk); drive(1,1,0,0,0,0,8'd100,3'b010);
        @(posedge clk); #1;
        check_output("dec_set", 2, 100, 0, 0, 1);
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk); drive(1,0,0,0,1,0,8'd100,3'b010);
            @(posedge clk); #1;
            exp_t = 100 - 1 - (n - 1) / 16;
            check_val($sformatf("decel_n%0d.target", n), target, 8'(exp_t));
        end
        @(negedge clk); drive(1,0,0,0,0,0,8'd100,3'b010);
        @(posedge clk); #1;
        check_output("decel_release", 2, 97, 0, 0, 1);

        // Asynchronous reset in the middle of an accel adjustment.
        @(negedge clk); drive(1,0,0,1,0,0,8'd100,3'b001);
        @(posedge clk); #1;
        check_output("pre_reset_adjust", 3, 98, 1, 0, 1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_output("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_output("post_reset", 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cruise_speed_regulator.md
# cruise_speed_regulator

Sequential cruise-control regulator that sits on the consuming side of the 8-bit speed comparator. It owns the cruise target speed, drives it onto the comparator's `b` input (with measured speed on `a`), and turns the comparator's G/Eq/L result into registered throttle-up/throttle-down commands. It also handles driver buttons (set, resume, accel, decel), brake disengage, and target stepping with saturation.

## Interface
- `MIN_SPEED`, 30: lowest legal target; set below this is ignored; decel saturates here.
- `MAX_SPEED`, 200: highest legal target; set above this is ignored; accel saturates here.
- `STEP_CYCLES`, 16: cycles between repeated ±1 target steps while accel/decel is held (≥2).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cruise_on`  in  1  master switch (level).
- `set_btn`  in  1  capture current speed as target (rising-edge sensitive).
- `resume_btn`  in  1  re-engage stored target (rising-edge sensitive).
- `accel_btn`  in  1  raise target (level).
- `decel_btn`  in  1  lower target (level).
- `brake`  in  1  brake pedal (level).
- `speed`  in  8  measured speed, unsigned.
- `G`, `Eq`, `L`  in  1 each  comparator result for speed vs target (G: speed > target).
- `target`  out  8  registered target speed; feeds comparator `b`.
- `throttle_up`  out  1  registered; request more throttle.
- `throttle_down`  out  1  registered; request less throttle.
- `engaged`  out  1  high in HOLD or ADJUST.
- `state`  out  2  current FSM state encoding.

## Operation
- States: OFF=0, STANDBY=1, HOLD=2, ADJUST=3.
- Priority, highest first: `cruise_on`=0, then `brake`, then buttons.
- OFF: `target`=0, `target_valid`=0. `cruise_on`=1 moves to STANDBY.
- STANDBY:
  - Set edge with MIN_SPEED ≤ `speed` ≤ MAX_SPEED: `target`←`speed`, `target_valid`=1, go to HOLD.
  - Set edge with `speed` out of range: ignored.
  - Resume edge: see Configuration.
- HOLD:
  - `brake` goes to STANDBY and keeps `target`.
  - Exactly one of `accel_btn`/`decel_btn` high: go to ADJUST and apply a ±1 step in the same cycle.
  - A new set edge re-captures `speed` (same range rule) and stays in HOLD.
- ADJUST:
  - Step counter reloads to 0 on entry.
  - A further ±1 step is applied every STEP_CYCLES cycles while the same button is held.
  - Release, or both buttons high, returns to HOLD with no step.
  - `brake` goes to STANDBY.
  - Steps saturate at MAX_SPEED/MIN_SPEED; the counter keeps running.
- Button edges: `set_btn`/`resume_btn` each have a 1-flop rising-edge detector. Holding a button never retriggers.
- Throttle, in HOLD/ADJUST only:
  - `throttle_up`←L, `throttle_down`←G.
  - Eq gives both 0.
  - Non-one-hot {G,Eq,L} gives both 0.
- Throttle in OFF/STANDBY: both 0.
- `throttle_up` and `throttle_down` are never both 1.

## Timing
- All outputs are registered.
- Reset values: `target`=0, `throttle_up`=0, `throttle_down`=0, `engaged`=0, `state`=OFF. Edge-detector flops and step counter are also 0.
- Comparator is combinational on `target`: throttle outputs reflect a target or speed change 1 cycle later.
- Set edge to `engaged`=1: 1 cycle.
- `brake` or `cruise_on`=0 to throttle outputs 0: 1 cycle.
- Accel held N cycles from HOLD: target gains 1 + floor((N−1)/STEP_CYCLES).
- `rst_n` asserted mid-ADJUST: immediate asynchronous return to reset values. No step occurs on deassertion.

## Configuration
- `CRUISE_RESUME_EN` defined:
  - Resume edge in STANDBY with `target_valid`=1 goes to HOLD with the stored `target`.
  - Resume edge with `target_valid`=0 is ignored.
- `CRUISE_RESUME_EN` undefined:
  - `resume_btn` is ignored and its edge flop is absent.
  - Brake clears `target` to 0 and `target_valid` to 0 on the STANDBY transition.

## Structure
- Shared package `cruise_pkg` holds:
  - state encodings OFF/STANDBY/HOLD/ADJUST;
  - the 8-bit speed width constant;
  - default MIN/MAX speed constants, also used by the comparator bench.
- One sub-module, `btn_edge`: 1-flop rising-edge detector with async active-low reset, instantiated for set and resume.
- Comparator is instantiated outside this block; G/Eq/L arrive as ports.

## Test plan
- Reset, then `cruise_on`=1, `speed`=60, set edge → HOLD, `target`=60, `engaged`=1 next cycle; G/Eq/L driven L → `throttle_up`=1 one cycle later.
- `set_btn` with `speed`=20 or 210 → stays STANDBY, `target` unchanged, throttles 0.
- HOLD at target=198, accel held 40 cycles (STEP_CYCLES=16) → target 199, 200, then saturates at 200; release → HOLD.
- HOLD target=80, brake → STANDBY next cycle, throttles 0. Then resume edge:
  - with `CRUISE_RESUME_EN`: HOLD, target=80;
  - without: ignored, target=0.
- `cruise_on` drops while in ADJUST with brake also high → OFF, `target`=0, in one cycle.
- {G,Eq,L}=3'b101 in HOLD → both throttles 0. `rst_n` pulsed mid-ADJUST → all outputs at reset values asynchronously.
